nn_layer_sequencer: RTL and testbench
=====================================

NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: start  input  1  request a layer run; sampled only in IDLE.
REQ-004 SHALL: n_in_chunks  input  8  16-element input chunks per neuron; latched on accepted start.
REQ-005 SHALL: n_out  input  10  neurons in the layer; latched on accepted start.
REQ-006 SHALL: busy  output  1  high whenever state is not IDLE.
REQ-007 SHALL: done  output  1  one-cycle completion pulse.
REQ-008 SHALL: x_addr  output  8  input-vector chunk address; x_rdata  input  512  16 x fp32, valid one cycle after address.
REQ-009 SHALL: w_addr  output  16  weight-row address; w_rdata  input  512  16 x fp32, valid one cycle after address.
REQ-010 SHALL: b_addr  output  10  bias address; b_rdata  input  32  fp32, valid one cycle after address.
REQ-011 SHALL: p_x, p_w  output  512 each; p_bias  output  32; p_out  input  32  connection to the combinational 16-lane dot-product-plus-bias unit (lane i = bits [32i+31:32i]).
REQ-012 SHALL: y_addr  output  10; y_data  output  32; y_we  output  1  result write port.

Function
REQ-013 SHALL: FSM states IDLE, FETCH, CALC, WRITE, DONE.
REQ-014 SHALL: IDLE + start with n_out!=0 and n_in_chunks!=0: latch counts, neuron=0, chunk=0, w_ptr=0, go FETCH.
REQ-015 SHALL: IDLE + start with n_out==0 or n_in_chunks==0: go DONE directly; no memory reads, no writes.
REQ-016 SHALL: FETCH: x_addr=chunk, w_addr=w_ptr, b_addr=neuron; next CALC.
REQ-017 SHALL: CALC: p_x=x_rdata, p_w=w_rdata, p_bias = (chunk==0) ? b_rdata : acc; acc <= p_out; w_ptr++.
REQ-018 SHALL: CALC with chunk==n_in_chunks-1 -> WRITE; otherwise chunk++ -> FETCH.
REQ-019 SHALL: WRITE: y_we=1, y_addr=neuron, y_data=acc (after REQ-030 if enabled); neuron==n_out-1 -> DONE, else neuron++, chunk=0 -> FETCH.
REQ-020 SHALL: DONE: done=1 for exactly one cycle, then IDLE.
REQ-021 SHALL: w_ptr be a running counter (neuron*n_in_chunks+chunk), no multiplier; 16-bit wrap is undefined use.
REQ-022 SHALL: cycles per neuron = 2*n_in_chunks+1; done asserted n_out*(2*n_in_chunks+1)+1 cycles after the accepting edge.
REQ-023 SHALL: start while busy be ignored; no requeue.
REQ-024 SHALL: p_x, p_w, p_bias be zero outside CALC; y_we low outside WRITE.
REQ-025 SHALL: latched counts not change mid-run if n_out/n_in_chunks inputs change.

Reset
REQ-026 SHALL: reset_n low force IDLE immediately, asynchronously.
REQ-027 SHALL: reset values: busy=0, done=0, y_we=0, all address/data outputs=0, acc=0, counters=0.
REQ-028 SHALL: reset mid-run abandon the run with no further write; next start runs from neuron 0.

Configuration
REQ-029 SHALL: macro NN_SEQ_RELU_EN select output activation.
REQ-030 SHALL: with NN_SEQ_RELU_EN defined, y_data = 32'h0 when acc[31]==1 (includes -0.0), else acc; without it, y_data = acc unchanged.

Verification
REQ-031 SHALL: n_out=1, n_in_chunks=1, all x=w=0x3F800000, bias 0 -> one write y_addr=0, y_data=0x41800000; done at cycle 4 after start.
REQ-032 SHALL: n_out=2, n_in_chunks=2, all ones, bias 0x3F800000 -> w_addr sequence 0,1,2,3; y_data=0x42040000 at y_addr 0 and 1; done at cycle 11.
REQ-033 SHALL: w=0xBF800000, x=0x3F800000, bias 0 -> y_data=0xC1800000 without NN_SEQ_RELU_EN, 0x00000000 with it.
REQ-034 SHALL: start with n_out=0 -> done on next cycle, busy high one cycle, y_we never asserted.
REQ-035 SHALL: reset_n pulsed low during CALC of neuron 1 (n_out=3) -> busy, y_we, done drop at once, no write for neuron 1; fresh start writes neurons 0..2.
REQ-036 SHALL: start re-asserted every cycle during a run -> single run, single done, write count equals n_out.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: per-neuron FETCH/CALC/WRITE walk over 16-lane chunks; 2*n_in_chunks+1 cycles per neuron, no backpressure.
// Define NN_SEQ_RELU_EN to clamp negative results (including -0.0) to zero on the write port.
module nn_layer_sequencer (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [7:0]   n_in_chunks,
  input  logic [9:0]   n_out,
  output logic         busy,
  output logic         done,
  output logic [7:0]   x_addr,
  input  logic [511:0] x_rdata,
  output logic [15:0]  w_addr,
  input  logic [511:0] w_rdata,
  output logic [9:0]   b_addr,
  input  logic [31:0]  b_rdata,
  output logic [511:0] p_x,
  output logic [511:0] p_w,
  output logic [31:0]  p_bias,
  input  logic [31:0]  p_out,
  output logic [9:0]   y_addr,
  output logic [31:0]  y_data,
  output logic         y_we
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CALC,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t       state_q;
  logic [7:0]   nin_q;
  logic [9:0]   nout_q;
  logic [9:0]   neuron_q;
  logic [7:0]   chunk_q;
  logic [15:0]  w_ptr_q;
  logic [31:0]  acc_q;
  logic         busy_q;
  logic         done_q;
  logic [7:0]   x_addr_q;
  logic [15:0]  w_addr_q;
  logic [9:0]   b_addr_q;
  logic [9:0]   y_addr_q;
  logic [31:0]  y_data_q;
  logic         y_we_q;

  logic [9:0]   neuron_d;
  logic [7:0]   chunk_d;
  logic [15:0]  w_ptr_d;
  logic [31:0]  act_d;
  logic         in_calc;
  logic         last_chunk;
  logic         last_neuron;

  assign neuron_d    = neuron_q + 10'd1;
  assign chunk_d     = chunk_q + 8'd1;
  assign w_ptr_d     = w_ptr_q + 16'd1;
  assign in_calc     = (state_q == ST_CALC);
  assign last_chunk  = (chunk_q == nin_q - 8'd1);
  assign last_neuron = (neuron_q == nout_q - 10'd1);

  // The datapath is combinational, so operands are gated straight from the memories.
  assign p_x    = in_calc ? x_rdata : '0;
  assign p_w    = in_calc ? w_rdata : '0;
  assign p_bias = in_calc ? ((chunk_q == 8'd0) ? b_rdata : acc_q) : '0;

`ifdef NN_SEQ_RELU_EN
  assign act_d = p_out[31] ? 32'h0 : p_out;
`else
  assign act_d = p_out;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign x_addr = x_addr_q;
  assign w_addr = w_addr_q;
  assign b_addr = b_addr_q;
  assign y_addr = y_addr_q;
  assign y_data = y_data_q;
  assign y_we   = y_we_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      nin_q    <= '0;
      nout_q   <= '0;
      neuron_q <= '0;
      chunk_q  <= '0;
      w_ptr_q  <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_addr_q <= '0;
      w_addr_q <= '0;
      b_addr_q <= '0;
      y_addr_q <= '0;
      y_data_q <= '0;
      y_we_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      y_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (n_out == '0 || n_in_chunks == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              nin_q    <= n_in_chunks;
              nout_q   <= n_out;
              neuron_q <= '0;
              chunk_q  <= '0;
              w_ptr_q  <= '0;
              x_addr_q <= '0;
              w_addr_q <= '0;
              b_addr_q <= '0;
              state_q  <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state_q <= ST_CALC;
        ST_CALC: begin
          acc_q   <= p_out;
          w_ptr_q <= w_ptr_d;
          if (last_chunk) begin
            y_we_q   <= 1'b1;
            y_addr_q <= neuron_q;
            y_data_q <= act_d;
            state_q  <= ST_WRITE;
          end else begin
            chunk_q  <= chunk_d;
            x_addr_q <= chunk_d;
            w_addr_q <= w_ptr_d;
            state_q  <= ST_FETCH;
          end
        end
        ST_WRITE: begin
          if (last_neuron) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            neuron_q <= neuron_d;
            chunk_q  <= '0;
            x_addr_q <= '0;
            w_addr_q <= w_ptr_q;
            b_addr_q <= neuron_d;
            state_q  <= ST_FETCH;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: integer-valued fp32 operands, a behavioural dot-product unit,
// and a scoreboard of expected writes and chunk addresses.
module tb_nn_layer_sequencer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [7:0]   n_in_chunks;
  logic [9:0]   n_out;
  logic         busy;
  logic         done;
  logic [7:0]   x_addr;
  logic [511:0] x_rdata;
  logic [15:0]  w_addr;
  logic [511:0] w_rdata;
  logic [9:0]   b_addr;
  logic [31:0]  b_rdata;
  logic [511:0] p_x;
  logic [511:0] p_w;
  logic [31:0]  p_bias;
  logic [31:0]  p_out;
  logic [9:0]   y_addr;
  logic [31:0]  y_data;
  logic         y_we;

  nn_layer_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .n_in_chunks(n_in_chunks), .n_out(n_out),
    .busy(busy), .done(done), .x_addr(x_addr), .x_rdata(x_rdata), .w_addr(w_addr),
    .w_rdata(w_rdata), .b_addr(b_addr), .b_rdata(b_rdata), .p_x(p_x), .p_w(p_w),
    .p_bias(p_bias), .p_out(p_out), .y_addr(y_addr), .y_data(y_data), .y_we(y_we)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  bit chk_addr = 1'b1;

  int x_int [256][16];
  int w_int [1024][16];
  int b_int [1024];

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;
  wr_t mon_e;
  wr_t exp_wr[$];
  int  exp_w[$];
  int  exp_x[$];
  logic [15:0] prev_w = '0;
  logic [7:0]  prev_x = '0;
  int pout_sum;

  function automatic logic [31:0] i2f(input int v);
    logic [31:0] m;
    int p;
    logic s;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    m = m << (23 - p);
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    int m;
    int v;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({8'd0, 1'b1, f[22:0]});
    if (e < 0) v = 0;
    else if (e >= 23) v = m <<< (e - 23);
    else v = m >>> (23 - e);
    return f[31] ? -v : v;
  endfunction

  // Memories answer one cycle after the address.
  always @(posedge clk) begin
    for (int l = 0; l < 16; l++) begin
      x_rdata[32*l +: 32] <= i2f(x_int[x_addr][l]);
      w_rdata[32*l +: 32] <= i2f(w_int[w_addr[9:0]][l]);
    end
    b_rdata <= i2f(b_int[b_addr]);
  end

  always_comb begin
    pout_sum = f2i(p_bias);
    for (int l = 0; l < 16; l++)
      pout_sum = pout_sum + f2i(p_x[32*l +: 32]) * f2i(p_w[32*l +: 32]);
    p_out = i2f(pout_sum);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (y_we) begin
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_write: y_addr=%0d y_data=%0h with nothing expected", y_addr, y_data);
      end else begin
        mon_e = exp_wr.pop_front();
        check("y_addr", longint'(y_addr), longint'(mon_e.addr));
        check("y_data", longint'(y_data), longint'(mon_e.data));
      end
    end
    if (done) done_cnt++;
    if (chk_addr && p_w != '0) begin
      if (exp_w.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_calc: w_addr=%0d with no chunk pending", prev_w);
      end else begin
        check("w_addr_seq", longint'(prev_w), longint'(exp_w.pop_front()));
        check("x_addr_seq", longint'(prev_x), longint'(exp_x.pop_front()));
      end
    end
    prev_w = w_addr;
    prev_x = x_addr;
  end

  function automatic int rnz();
    int v;
    v = int'($urandom_range(0, 5));
    return (v < 3) ? v - 3 : v - 2;
  endfunction

  task automatic fill_const(input int xv, input int wv, input int bv);
    for (int i = 0; i < 1024; i++) begin
      for (int l = 0; l < 16; l++) begin
        if (i < 256) x_int[i][l] = xv;
        w_int[i][l] = wv;
      end
      b_int[i] = bv;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin
      for (int l = 0; l < 16; l++) begin
        x_int[i][l] = rnz();
        w_int[i][l] = rnz();
      end
      b_int[i] = int'($urandom_range(0, 100)) - 50;
    end
  endtask

  // Neuron j of a layer reads input chunk c against weight row j*nin+c.
  task automatic push_neuron(input int j, input int nin);
    wr_t e;
    int s;
    s = b_int[j];
    for (int c = 0; c < nin; c++) begin
      for (int l = 0; l < 16; l++) s += x_int[c][l] * w_int[j*nin + c][l];
      exp_w.push_back(j*nin + c);
      exp_x.push_back(c);
    end
    e.addr = j;
`ifdef NN_SEQ_RELU_EN
    e.data = (s < 0) ? 32'h0 : i2f(s);
`else
    e.data = i2f(s);
`endif
    exp_wr.push_back(e);
  endtask

  task automatic run(input int nout, input int nin, input bit hold);
    int lat_exp;
    int cyc;
    int busy_cyc;
    int wr0;
    int dn0;
    int nwr;
    bit seen;
    nwr = (nout == 0 || nin == 0) ? 0 : nout;
    lat_exp = (nwr == 0) ? 1 : nout*(2*nin + 1) + 1;
    for (int j = 0; j < nwr; j++) push_neuron(j, nin);
    @(negedge clk);
    n_out = 10'(nout);
    n_in_chunks = 8'(nin);
    start = 1'b1;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    cyc = 0;
    busy_cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'b0;
      n_out = 10'($urandom);
      n_in_chunks = 8'($urandom);
      if (busy) busy_cyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", longint'(seen), 1);
    check("done_latency", cyc, lat_exp);
    check("busy_cycles", busy_cyc, lat_exp);
    @(negedge clk);
    check("done_pulse_width", longint'(done), 0);
    check("busy_after_done", longint'(busy), 0);
    check("operands_idle_zero", longint'({p_x, p_w, p_bias} == '0), 1);
    check("write_count", wr_cnt - wr0, nwr);
    check("done_count", done_cnt - dn0, 1);
    check("writes_outstanding", exp_wr.size(), 0);
    check("chunks_outstanding", exp_w.size(), 0);
  endtask

  task automatic reset_mid_run();
    int wr0;
    int guard;
    fill_rand();
    chk_addr = 1'b0;
    push_neuron(0, 2);
    exp_w.delete();
    exp_x.delete();
    @(negedge clk);
    n_out = 10'd3;
    n_in_chunks = 8'd2;
    start = 1'b1;
    wr0 = wr_cnt;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (wr_cnt == wr0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rst_first_write_seen", wr_cnt - wr0, 1);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (p_w == '0 && guard < 200);
    check("rst_reached_calc", longint'(p_w != '0), 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy_drop", longint'(busy), 0);
    check("rst_y_we_drop", longint'(y_we), 0);
    check("rst_done_drop", longint'(done), 0);
    check("rst_operands_drop", longint'(p_w != '0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_further_write", wr_cnt - wr0, 1);
    check("rst_idle", longint'(busy), 0);
    chk_addr = 1'b1;
    run(3, 2, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    n_out = '0;
    n_in_chunks = '0;
    fill_const(0, 0, 0);
    #12;
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_y_we", longint'(y_we), 0);
    check("reset_addrs", longint'({x_addr, w_addr, b_addr, y_addr}), 0);
    check("reset_y_data", longint'(y_data), 0);
    check("reset_operands", longint'({p_x, p_w, p_bias} == '0), 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    fill_const(1, 1, 0);
    run(1, 1, 1'b0);
    fill_const(1, 1, 1);
    run(2, 2, 1'b0);
    fill_const(1, -1, 0);
    run(1, 1, 1'b0);
    run(0, 3, 1'b0);
    run(4, 0, 1'b0);
    fill_rand();
    run(3, 2, 1'b1);
    reset_mid_run();
    for (int r = 0; r < 8; r++) begin
      fill_rand();
      run(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
